// File: rtl/spectrum_accumulator.sv
// rtl/spectrum_accumulator.sv - bin-wise multi-pulse spectrum accumulator with streamed dump.
// Optional macro ACC_SATURATE_EN: saturating add plus sticky sat_flag output.
module spectrum_accumulator #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int NBINS = 256,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Capture_En,
  input  logic             data_valid_i,
  input  logic [IN_W-1:0]  data_i,
  input  logic [15:0]      Pulse_counts,
  input  logic             is_first_pls,
  input  logic [15:0]      Accum_target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_last,
  output logic             frame_done,
  output logic             len_err,
  output logic             busy
`ifdef ACC_SATURATE_EN
  ,
  output logic             sat_flag
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DUMP} state_t;

  localparam logic [AW:0]   ONE_A   = (AW+1)'(1);
  localparam logic [AW:0]   NBINS_A = (AW+1)'(NBINS);
  localparam logic [AW-1:0] LAST_A  = AW'(NBINS - 1);

  state_t            state_q, state_d;
  logic [AW:0]       bin_addr_q, bin_addr_d;
  logic              dv_prev_q, dv_prev_d;
  logic              first_q, first_d;
  logic [15:0]       idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [IN_W-1:0]   wr_data_q, wr_data_d;
  logic              fin_pend_q, fin_pend_d;
  logic              len_err_q, len_err_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic [ACC_W-1:0]  ent0_q, ent0_d, ent1_q, ent1_d;
  logic [AW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              frame_done_q, frame_done_d;
  logic              sat_q, sat_d;

  logic [ACC_W-1:0]  mem [NBINS];
  logic [ACC_W-1:0]  ram_rd_q;
  logic [AW-1:0]     rd_addr;
  logic [ACC_W:0]    add_full;
  logic [ACC_W-1:0]  wr_val;
  logic              accept, pls_start, in_range, falling, is_final;
  logic              pop, push, issue;
  logic [2:0]        occ;

  assign accept    = Capture_En && data_valid_i && (state_q != S_DUMP);
  assign pls_start = accept && !dv_prev_q;
  assign in_range  = !bin_addr_q[AW];
  assign falling   = dv_prev_q && !data_valid_i && (state_q == S_ACCUM);
  assign is_final  = (Accum_target == 16'd0) || (idx_q == Accum_target - 16'd1);

  assign out_valid  = (fcnt_q != 2'd0);
  assign out_data   = ent0_q;
  assign out_last   = out_valid && (beat_cnt_q == LAST_A);
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;
  assign busy       = (state_q != S_IDLE);

  assign pop   = out_valid && out_ready;
  assign push  = rd_pend_q;
  // Occupancy counts the in-flight RAM read so the 2-entry prefetch never overflows.
  assign occ   = {1'b0, fcnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue = (state_q == S_DUMP) && (rd_ptr_q < NBINS_A) && (occ < 3'd2);
  assign rd_addr = (state_q == S_DUMP) ? rd_ptr_q[AW-1:0] : bin_addr_q[AW-1:0];

  assign add_full = {1'b0, ram_rd_q} + (ACC_W+1)'(wr_data_q);

  always_comb begin
    wr_val = add_full[ACC_W-1:0];
    sat_d  = sat_q;
    if (first_q) begin
      wr_val = ACC_W'(wr_data_q);
    end else if (add_full[ACC_W]) begin
`ifdef ACC_SATURATE_EN
      wr_val = {ACC_W{1'b1}};
      if (wr_en_q) sat_d = 1'b1;
`endif
    end
    if (!Capture_En) sat_d = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    bin_addr_d   = bin_addr_q;
    dv_prev_d    = data_valid_i && Capture_En;
    first_d      = first_q;
    idx_d        = idx_q;
    wr_en_d      = accept && in_range;
    wr_addr_d    = bin_addr_q[AW-1:0];
    wr_data_d    = data_i;
    fin_pend_d   = fin_pend_q;
    len_err_d    = len_err_q;
    rd_ptr_d     = rd_ptr_q;
    rd_pend_d    = issue;
    fcnt_d       = fcnt_q;
    ent0_d       = ent0_q;
    ent1_d       = ent1_q;
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;

    if (pls_start) begin
      first_d = is_first_pls;
      idx_d   = Pulse_counts;
    end
    if (accept && !in_range) len_err_d = 1'b1;
    if (!data_valid_i) bin_addr_d = '0;
    else if (accept && in_range) bin_addr_d = bin_addr_q + ONE_A;

    if (issue) rd_ptr_d = rd_ptr_q + ONE_A;
    if (pop) begin
      ent0_d     = ent1_q;
      fcnt_d     = fcnt_d - 2'd1;
      beat_cnt_d = beat_cnt_q + AW'(1);
    end
    if (push) begin
      if (fcnt_d == 2'd0) ent0_d = ram_rd_q;
      else                ent1_d = ram_rd_q;
      fcnt_d = fcnt_d + 2'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        // One extra cycle lets the last bin's write land before the dump reads start.
        if (fin_pend_q) begin
          state_d    = S_DUMP;
          fin_pend_d = 1'b0;
        end else if (falling && is_final) begin
          fin_pend_d = 1'b1;
        end
      end
      S_DUMP: begin
        if (pop && out_last) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
          rd_ptr_d     = '0;
          rd_pend_d    = 1'b0;
          fcnt_d       = 2'd0;
          beat_cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!Capture_En) begin
      state_d      = S_IDLE;
      bin_addr_d   = '0;
      fin_pend_d   = 1'b0;
      len_err_d    = 1'b0;
      rd_ptr_d     = '0;
      rd_pend_d    = 1'b0;
      fcnt_d       = 2'd0;
      beat_cnt_d   = '0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bin_addr_q   <= '0;
      dv_prev_q    <= 1'b0;
      first_q      <= 1'b0;
      idx_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      fin_pend_q   <= 1'b0;
      len_err_q    <= 1'b0;
      rd_ptr_q     <= '0;
      rd_pend_q    <= 1'b0;
      fcnt_q       <= 2'd0;
      ent0_q       <= '0;
      ent1_q       <= '0;
      beat_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_addr_q   <= bin_addr_d;
      dv_prev_q    <= dv_prev_d;
      first_q      <= first_d;
      idx_q        <= idx_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      fin_pend_q   <= fin_pend_d;
      len_err_q    <= len_err_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_pend_q    <= rd_pend_d;
      fcnt_q       <= fcnt_d;
      ent0_q       <= ent0_d;
      ent1_q       <= ent1_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
      sat_q        <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_q) mem[wr_addr_q] <= wr_val;
    ram_rd_q <= mem[rd_addr];
  end

`ifdef ACC_SATURATE_EN
  assign sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_spectrum_accumulator.sv
// tb/tb_spectrum_accumulator.sv - directed bench for spectrum_accumulator (ACC_W=17).
module tb_spectrum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Capture_En;
  logic        data_valid_i;
  logic [15:0] data_i;
  logic [15:0] Pulse_counts;
  logic        is_first_pls;
  logic [15:0] Accum_target;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out_data;
  logic        out_last;
  logic        frame_done;
  logic        len_err;
  logic        busy;
`ifdef ACC_SATURATE_EN
  logic        sat_flag;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  spectrum_accumulator #(.IN_W(16), .ACC_W(17), .NBINS(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .Capture_En(Capture_En),
    .data_valid_i(data_valid_i), .data_i(data_i),
    .Pulse_counts(Pulse_counts), .is_first_pls(is_first_pls),
    .Accum_target(Accum_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_done(frame_done), .len_err(len_err),
    .busy(busy)
`ifdef ACC_SATURATE_EN
    , .sat_flag(sat_flag)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(input int idx, input int nbins, input int vmode, input int cval);
    Pulse_counts = 16'(idx);
    is_first_pls = (idx == 0);
    for (int k = 0; k < nbins; k++) begin
      data_valid_i = 1'b1;
      data_i = (vmode == 0) ? 16'(k) : 16'(cval);
      tick();
    end
    data_valid_i = 1'b0;
    data_i = '0;
    repeat (3) tick();
  endtask

  // Expected beat value: mult*bin for vmode 0, constant cval otherwise.
  task automatic dump_check(input string tag, input int vmode, input int mult,
                            input logic [31:0] cval, input bit stall, input int stop_after);
    int beats = 0;
    bit held = 1'b0;
    logic [31:0] hold_d = '0;
    logic [31:0] expv;
    for (int cyc = 0; cyc < 3000 && beats < stop_after; cyc++) begin
      out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (out_valid) begin
        if (held) chk({tag, "_hold"}, 32'(out_data), hold_d);
        if (out_ready) begin
          expv = (vmode == 0) ? 32'(mult * beats) : cval;
          chk({tag, "_data"}, 32'(out_data), expv);
          chk({tag, "_last"}, 32'(out_last), 32'(beats == 255));
          beats++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          hold_d = 32'(out_data);
        end
      end
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_beats"}, 32'(beats), 32'(stop_after));
    if (stop_after == 256) begin
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      tick();
      chk({tag, "_frame_done_pulse"}, 32'(frame_done), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    Capture_En = 1'b1;
    data_valid_i = 1'b0;
    data_i = '0;
    Pulse_counts = '0;
    is_first_pls = 1'b0;
    Accum_target = 16'd4;
    out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef ACC_SATURATE_EN
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Four pulses of bin index -> 4k per bin
    Accum_target = 16'd4;
    send_pulse(0, 256, 0, 0);
    chk("t1_busy_accum", 32'(busy), 32'd1);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    for (int p = 1; p < 4; p++) send_pulse(p, 256, 0, 0);
    dump_check("t1", 0, 4, 0, 1'b0, 256);
    chk("t1_len_err", 32'(len_err), 32'd0);

    // Stale 0xDEAD frame, then first pulse overwrites; dump with stalled ready
    Accum_target = 16'd1;
    send_pulse(0, 256, 1, 'hDEAD);
    dump_check("pre", 1, 0, 32'hDEAD, 1'b0, 256);
    Accum_target = 16'd2;
    send_pulse(0, 256, 1, 100);
    send_pulse(1, 256, 1, 5);
    dump_check("t2", 1, 0, 32'd105, 1'b1, 256);

    // Overlong pulse: 260 bins, last 4 dropped
    Accum_target = 16'd1;
    send_pulse(0, 260, 0, 0);
    chk("t4_len_err_set", 32'(len_err), 32'd1);
    dump_check("t4", 0, 1, 0, 1'b0, 256);
    chk("t4_len_err_held", 32'(len_err), 32'd1);
    Capture_En = 1'b0;
    tick();
    chk("t4_len_err_clr", 32'(len_err), 32'd0);
    Capture_En = 1'b1;
    tick();

    // Abort mid-dump at beat 100, then fresh single-pulse capture
    send_pulse(0, 256, 1, 7);
    dump_check("t5a", 1, 0, 32'd7, 1'b0, 100);
    Capture_En = 1'b0;
    tick();
    chk("t5_abort_valid", 32'(out_valid), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    Capture_En = 1'b1;
    tick();
    send_pulse(0, 256, 1, 9);
    dump_check("t5b", 1, 0, 32'd9, 1'b0, 256);

    // Overflow: 3 x 0xFFFF in 17 bits
    Accum_target = 16'd3;
    for (int p = 0; p < 3; p++) send_pulse(p, 256, 1, 'hFFFF);
`ifdef ACC_SATURATE_EN
    chk("t6_sat_flag", 32'(sat_flag), 32'd1);
    dump_check("t6", 1, 0, 32'h1FFFF, 1'b0, 256);
`else
    dump_check("t6", 1, 0, 32'h0FFFD, 1'b0, 256);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
